// File: rtl/adc_interleave_ctrl_if.sv
// Control/status bundle between the interleave sequencer and the x2 ADC front end.
// master = sequencer side, slave = ADC/mux/host side.
interface adc_interleave_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             err_clr;
    logic             adc_done_0;
    logic             adc_done_1;
    logic             adc_start_0;
    logic             adc_start_1;
    logic             x_adc_select;
    logic             x_adc_valid;
    logic             x_adc_ch;
    logic             overrun;
    logic             timeout;
    logic [CNT_W-1:0] sample_count;

    modport master (
        input  enable, err_clr, adc_done_0, adc_done_1,
        output adc_start_0, adc_start_1, x_adc_select, x_adc_valid,
        output x_adc_ch, overrun, timeout, sample_count
    );

    modport slave (
        output enable, err_clr, adc_done_0, adc_done_1,
        input  adc_start_0, adc_start_1, x_adc_select, x_adc_valid,
        input  x_adc_ch, overrun, timeout, sample_count
    );
endinterface

// File: rtl/adc_interleave_ctrl.sv
// Start/done sequencer for a x2 time-interleaved ADC with registered output mux.
// Starts alternate per period slot; finished channels are served oldest-first.
module adc_interleave_ctrl #(
    parameter int SAMPLE_PERIOD = 8,
    parameter int TIMEOUT       = 16,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    adc_interleave_ctrl_if.master bus
);
    localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int AW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_PEND} ch_st_e;

    ch_st_e           st_q  [2];
    ch_st_e           st_d  [2];
    logic [AW-1:0]    age_q [2];
    logic [AW-1:0]    age_d [2];
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             nxt_q, nxt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             srv_q, srv_d;
    logic             vld_q, vld_d;
    logic             xch_q, xch_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [1:0]       done, start, cand;
    logic             slot, srv_ch;

    always_comb begin
        done   = {bus.adc_done_1, bus.adc_done_0};
        slot   = bus.enable && (cnt_q == '0);
        start  = '0;
        st_d   = st_q;
        age_d  = age_q;
        nxt_d  = nxt_q;
        last_d = last_q;
        sel_d  = sel_q;
        srv_d  = 1'b0;
        vld_d  = srv_q;
        xch_d  = xch_q;
        scnt_d = scnt_q;
        ovr_d  = ovr_q & ~bus.err_clr;
        to_d   = to_q & ~bus.err_clr;
        cand   = '0;
        srv_ch = 1'b0;

        if (!bus.enable || cnt_q == PW'(SAMPLE_PERIOD - 1))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        if (slot) begin
            nxt_d = ~nxt_q;
            if (st_q[nxt_q] == S_IDLE) begin
                start[nxt_q] = 1'b1;
                last_d       = nxt_q;
            end else begin
                ovr_d = 1'b1;
            end
        end

        for (int k = 0; k < 2; k++) begin
            cand[k] = (st_q[k] == S_PEND) ||
                      (st_q[k] == S_CONV && done[k]);
            unique case (st_q[k])
                S_IDLE: begin
                    if (start[k]) begin
                        st_d[k]  = S_CONV;
                        age_d[k] = AW'(1);
                    end
                end
                S_CONV: begin
                    if (done[k]) begin
                        st_d[k] = S_PEND;
                    end else if (age_q[k] == AW'(TIMEOUT - 1)) begin
                        st_d[k] = S_IDLE;
                        to_d    = 1'b1;
                    end else begin
                        age_d[k] = age_q[k] + 1'b1;
                    end
                end
                S_PEND: ;
                default: st_d[k] = S_IDLE;
            endcase
        end

        // with both ready, the channel not started last is the older one
        srv_ch = (cand == 2'b11) ? ~last_q : cand[1];
        if (|cand) begin
            st_d[srv_ch] = S_IDLE;
            sel_d        = srv_ch;
            srv_d        = 1'b1;
        end

        if (srv_q) begin
            xch_d  = sel_q;
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            st_q[0]  <= S_IDLE;
            st_q[1]  <= S_IDLE;
            age_q[0] <= '0;
            age_q[1] <= '0;
            cnt_q    <= '0;
            nxt_q    <= 1'b0;
            last_q   <= 1'b0;
            sel_q    <= 1'b0;
            srv_q    <= 1'b0;
            vld_q    <= 1'b0;
            xch_q    <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
            scnt_q   <= '0;
        end else begin
            st_q   <= st_d;
            age_q  <= age_d;
            cnt_q  <= cnt_d;
            nxt_q  <= nxt_d;
            last_q <= last_d;
            sel_q  <= sel_d;
            srv_q  <= srv_d;
            vld_q  <= vld_d;
            xch_q  <= xch_d;
            ovr_q  <= ovr_d;
            to_q   <= to_d;
            scnt_q <= scnt_d;
        end
    end

    // starts are combinational so they land in the slot cycle itself
    assign bus.adc_start_0  = start[0] & ~GlobalReset;
    assign bus.adc_start_1  = start[1] & ~GlobalReset;
    assign bus.x_adc_select = sel_q;
    assign bus.x_adc_valid  = vld_q;
    assign bus.x_adc_ch     = xch_q;
    assign bus.overrun      = ovr_q;
    assign bus.timeout      = to_q;
    assign bus.sample_count = scnt_q;
endmodule

// File: tb/tb_adc_interleave_ctrl.sv
// Randomized bench: cycle-level reference model of slots, conversions and
// oldest-first service feeding a scoreboard checked by a valid monitor.
module tb_adc_interleave_ctrl;
    localparam int P  = 8;
    localparam int TO = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic GlobalReset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    adc_interleave_ctrl_if #(.CNT_W(CW)) bus ();

    adc_interleave_ctrl #(
        .SAMPLE_PERIOD(P),
        .TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int ch; int st;} rq_t;
    typedef struct {int ch; int due;} sb_t;

    rq_t rq[$];
    sb_t sbq[$];
    int  st_time[2];
    int  done_at[2];
    int  phase, nxt, dmode, pops;
    bit  vis_sel, vis_ovr, vis_to;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int pick_delay(int k);
        case (dmode)
            0: return $urandom_range(1, 7);
            2: return (k == 0) ? 12 : 4;
            default: begin
                if ($urandom_range(0, 5) == 0) return -1;
                return $urandom_range(1, TO + 6);
            end
        endcase
    endfunction

    function automatic bit queued(int k);
        foreach (rq[i]) if (rq[i].ch == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic enqueue(int k, int st);
        int pos = rq.size();
        for (int i = rq.size() - 1; i >= 0; i--)
            if (rq[i].st > st) pos = i;
        rq.insert(pos, '{k, st});
    endtask

    task automatic model_reset();
        rq.delete();
        sbq.delete();
        for (int k = 0; k < 2; k++) begin
            st_time[k] = -1;
            done_at[k] = -1;
        end
        phase   = 0;
        nxt     = 0;
        vis_sel = 0;
        vis_ovr = 0;
        vis_to  = 0;
    endtask

    // reference model: evaluates each cycle once inputs are stable
    always @(negedge clk) begin : model
        logic [1:0] dn;
        bit   [1:0] sexp;
        bit         ov, te, nsel;
        int         d;
        rq_t        r;
        if (GlobalReset) begin
            model_reset();
        end else begin
            dn = {bus.adc_done_1, bus.adc_done_0};
            chk("x_adc_select", int'(bus.x_adc_select), int'(vis_sel));
            chk("overrun", int'(bus.overrun), int'(vis_ovr));
            chk("timeout", int'(bus.timeout), int'(vis_to));
            sexp = '0;
            ov   = 0;
            te   = 0;
            nsel = vis_sel;
            if (bus.enable && phase == 0) begin
                if (st_time[nxt] < 0 && !queued(nxt)) sexp[nxt] = 1'b1;
                else ov = 1;
                nxt = 1 - nxt;
            end
            chk("adc_start_0", int'(bus.adc_start_0), int'(sexp[0]));
            chk("adc_start_1", int'(bus.adc_start_1), int'(sexp[1]));
            for (int k = 0; k < 2; k++) begin
                if (st_time[k] >= 0 && cyc > st_time[k]) begin
                    if (dn[k]) begin
                        enqueue(k, st_time[k]);
                        st_time[k] = -1;
                    end else if (cyc - st_time[k] == TO - 1) begin
                        te = 1;
                        st_time[k] = -1;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (sexp[k]) begin
                    st_time[k] = cyc;
                    d = pick_delay(k);
                    done_at[k] = (d < 0) ? -1 : cyc + d;
                end
            end
            if (rq.size() > 0) begin
                r = rq.pop_front();
                sbq.push_back('{r.ch, cyc + 2});
                nsel = r.ch[0];
            end
            phase   = bus.enable ? (phase + 1) % P : 0;
            vis_sel = nsel;
            vis_ovr = (vis_ovr & !bus.err_clr) | ov;
            vis_to  = (vis_to & !bus.err_clr) | te;
        end
    end

    always @(negedge clk) begin : monitor
        sb_t e;
        if (GlobalReset) begin
            pops = 0;
        end else begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                chk("valid_missing", 0, 1);
            end
            if (bus.x_adc_valid) begin
                if (sbq.size() == 0 || sbq[0].due != cyc) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    pops++;
                    chk("x_adc_ch", int'(bus.x_adc_ch), e.ch);
                    chk("sample_count", int'(bus.sample_count), pops % (1 << CW));
                end
            end
        end
    end

    task automatic drive(bit en, bit noise);
        @(posedge clk);
        #1;
        bus.enable     = en;
        bus.adc_done_0 = (done_at[0] == cyc) ||
                         (noise && $urandom_range(0, 39) == 0);
        bus.adc_done_1 = (done_at[1] == cyc) ||
                         (noise && $urandom_range(0, 39) == 0);
        bus.err_clr    = noise && $urandom_range(0, 19) == 0;
    endtask

    task automatic run(int n, bit en, bit noise);
        repeat (n) drive(en, noise);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_start0"}, int'(bus.adc_start_0), 0);
        chk({tag, "_start1"}, int'(bus.adc_start_1), 0);
        chk({tag, "_select"}, int'(bus.x_adc_select), 0);
        chk({tag, "_valid"}, int'(bus.x_adc_valid), 0);
        chk({tag, "_ch"}, int'(bus.x_adc_ch), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
        chk({tag, "_timeout"}, int'(bus.timeout), 0);
        chk({tag, "_count"}, int'(bus.sample_count), 0);
    endtask

    initial begin
        GlobalReset      = 1'b1;
        bus.enable       = 1'b1;
        bus.err_clr      = 1'b0;
        bus.adc_done_0   = 1'b0;
        bus.adc_done_1   = 1'b0;
        dmode            = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        bus.enable  = 1'b0;
        GlobalReset = 1'b0;

        dmode = 0;
        run(200, 1, 0);
        chk("clean_overrun", int'(bus.overrun), 0);
        chk("clean_timeout", int'(bus.timeout), 0);

        dmode = 2;
        run(96, 1, 0);

        dmode = 1;
        run(500, 1, 1);
        run(60, 0, 0);
        chk("drained_after_disable", sbq.size(), 0);

        dmode = 1;
        run(150, 1, 1);
        run(5, 1, 0);
        @(posedge clk);
        #3;
        GlobalReset = 1'b1;
        #1;
        check_zero("async_reset");
        bus.enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.adc_done_0 = ~bus.adc_done_0;
            bus.adc_done_1 = ~bus.adc_done_1;
        end
        GlobalReset = 1'b0;
        run(30, 0, 1);

        dmode = 1;
        run(200, 1, 1);
        dmode = 0;
        run(60, 1, 0);
        run(60, 0, 0);
        chk("drained_final", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
